// File: rtl/job_arb_pkg.sv
// Shared definitions for the round-robin job arbiter: FSM encodings,
// default watchdog limit and an index-width helper.
package job_arb_pkg;

   typedef enum logic [1:0] {
      STATE_IDLE    = 2'd0,
      STATE_RUN     = 2'd1,
      STATE_RELEASE = 2'd2
   } state_t;

   localparam logic [19:0] DEFAULT_TIMEOUT_CYCLES = 20'd600000;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/job_arbiter_rr_if.sv
// Requester/processing-unit signal bundle for job_arbiter_rr.
// timeoutOut exists only when JOB_ARBITER_TIMEOUT_EN is defined.
interface job_arbiter_rr_if #(parameter int NUM_REQ = 4);

   // Handshake: a requester holds reqIn high until it sees its grantOut bit;
   // the unit sees goOut high, raises doneIn, and must drop doneIn after goOut
   // falls before the next grant can be issued (a four-phase go/done loop).
   logic [NUM_REQ-1:0] reqIn;
   logic [NUM_REQ-1:0] grantOut;
   logic               goOut;
   logic               doneIn;
   logic               busyOut;
   logic [7:0]         jobCount;
`ifdef JOB_ARBITER_TIMEOUT_EN
   logic               timeoutOut;
`endif

   modport master (
      input  reqIn,
      input  doneIn,
`ifdef JOB_ARBITER_TIMEOUT_EN
      output timeoutOut,
`endif
      output grantOut,
      output goOut,
      output busyOut,
      output jobCount
   );

   modport slave (
      output reqIn,
      output doneIn,
`ifdef JOB_ARBITER_TIMEOUT_EN
      input  timeoutOut,
`endif
      input  grantOut,
      input  goOut,
      input  busyOut,
      input  jobCount
   );

endinterface

// File: rtl/job_arbiter_rr_rr_pick.sv
// Combinational round-robin search: first asserted request at or above
// rrPtr, wrapping from the top index back to zero.
module rr_pick
   import job_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] reqIn,
   input  logic [IDX_W-1:0]   rrPtr,
   output logic [IDX_W-1:0]   winnerOut,
   output logic               anyReq
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      winnerOut = '0;
      anyReq    = 1'b0;
      idx       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = IDX_W'((int'(rrPtr) + i) % NUM_REQ);
         if (!anyReq && reqIn[idx]) begin
            anyReq    = 1'b1;
            winnerOut = idx;
         end
      end
   end

endmodule

// File: rtl/job_arbiter_rr.sv
// Round-robin arbiter handing one go/done processing unit to NUM_REQ
// requesters. Optional watchdog enabled by JOB_ARBITER_TIMEOUT_EN.
module job_arbiter_rr
   import job_arb_pkg::*;
#(
   parameter int          NUM_REQ        = 4,
   parameter logic [19:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic             clk,
   input  logic             rstNInput,
   job_arbiter_rr_if.master bus,
   output state_t           dbg_state_o
);

   localparam int IDX_W = idx_width(NUM_REQ);

   // Reset asserts asynchronously but is released two clocks later.
   logic [1:0] rst_sync_q;
   logic       rst_n_int;

   always_ff @(posedge clk or negedge rstNInput) begin
      if (!rstNInput) rst_sync_q <= 2'b00;
      else            rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign rst_n_int = rst_sync_q[1];

   state_t           state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [7:0]       count_q, count_d;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic [IDX_W-1:0] next_ptr;
   logic             job_active;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .reqIn     (bus.reqIn),
      .rrPtr     (rr_ptr_q),
      .winnerOut (pick_idx),
      .anyReq    (pick_any)
   );

   assign job_active = (state_q == STATE_RUN) || (state_q == STATE_RELEASE);
   assign next_ptr   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

`ifdef JOB_ARBITER_TIMEOUT_EN
   logic [19:0] wdog_q, wdog_d;
   logic        timeout_hit;

   assign timeout_hit    = job_active && (wdog_q == TIMEOUT_CYCLES - 20'd1);
   assign bus.timeoutOut = timeout_hit;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      count_d  = count_q;
`ifdef JOB_ARBITER_TIMEOUT_EN
      wdog_d   = '0;
`endif
      case (state_q)
         // A done level still high from the previous job blocks a new grant.
         STATE_IDLE: begin
            if (pick_any && !bus.doneIn) begin
               state_d = STATE_RUN;
               owner_d = pick_idx;
            end
         end
         STATE_RUN: begin
            if (bus.doneIn) state_d = STATE_RELEASE;
         end
         STATE_RELEASE: begin
            if (!bus.doneIn) begin
               state_d  = STATE_IDLE;
               rr_ptr_d = next_ptr;
               count_d  = count_q + 8'd1;
            end
         end
         default: state_d = STATE_IDLE;
      endcase
`ifdef JOB_ARBITER_TIMEOUT_EN
      if (job_active) begin
         wdog_d = wdog_q + 20'd1;
         // An expired job is abandoned: not counted, but the pointer moves on.
         if (timeout_hit) begin
            state_d  = STATE_IDLE;
            rr_ptr_d = next_ptr;
            count_d  = count_q;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_q  <= STATE_IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         count_q  <= count_d;
      end
   end

`ifdef JOB_ARBITER_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) wdog_q <= '0;
      else            wdog_q <= wdog_d;
   end
`endif

   logic [NUM_REQ-1:0] grant;

   always_comb begin
      grant = '0;
      if (job_active) grant[owner_q] = 1'b1;
   end

   assign bus.grantOut = grant;
   assign bus.busyOut  = |grant;
   assign bus.goOut    = (state_q == STATE_RUN);
   assign bus.jobCount = count_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_job_arbiter_rr.sv
// Directed bench for job_arbiter_rr: vector table plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_job_arbiter_rr;
   import job_arb_pkg::*;

   logic   clk;
   logic   rstNInput;
   state_t dbg_state;

   job_arbiter_rr_if #(.NUM_REQ(4)) bus ();

   job_arbiter_rr #(.NUM_REQ(4), .TIMEOUT_CYCLES(20'd16)) dut (
      .clk         (clk),
      .rstNInput   (rstNInput),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #41.667 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [3:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rstNInput  = 1'b0;
      bus.reqIn  = '0;
      bus.doneIn = 1'b0;
      repeat (2) @(negedge clk);
      rstNInput = 1'b1;
      // two edges for the internal reset synchronizer
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_busy(input string name, input logic level);
      int k;
      k = 0;
      while (bus.busyOut !== level && k < 10) begin
         cycle();
         k++;
      end
      check(name, 32'(bus.busyOut), 32'(level));
   endtask

   task automatic do_job(output logic [3:0] granted);
      int k;
      wait_busy("job start", 1'b1);
      granted    = bus.grantOut;
      bus.doneIn = 1'b1;
      k = 0;
      do begin
         cycle();
         k++;
      end while (bus.goOut !== 1'b0 && k < 10);
      check("job go drop", 32'(bus.goOut), 32'd0);
      bus.doneIn = 1'b0;
      cycle();
      wait_busy("job end", 1'b0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [3:0] req;
      logic       done;
      logic [3:0] grant;
      logic       go;
      logic       busy;
      logic [7:0] cnt;
      logic [1:0] st;
   } vec_t;

   vec_t vecs[23];
   logic [3:0] g;

   initial begin
      vecs[0]  = '{4'b0101, 1'b0, 4'b0001, 1'b1, 1'b1, 8'd0, 2'd1};
      vecs[1]  = '{4'b0101, 1'b0, 4'b0001, 1'b1, 1'b1, 8'd0, 2'd1};
      vecs[2]  = '{4'b0101, 1'b1, 4'b0001, 1'b0, 1'b1, 8'd0, 2'd2};
      vecs[3]  = '{4'b0101, 1'b1, 4'b0001, 1'b0, 1'b1, 8'd0, 2'd2};
      vecs[4]  = '{4'b0101, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd1, 2'd0};
      vecs[5]  = '{4'b0101, 1'b0, 4'b0100, 1'b1, 1'b1, 8'd1, 2'd1};
      vecs[6]  = '{4'b0000, 1'b1, 4'b0100, 1'b0, 1'b1, 8'd1, 2'd2};
      vecs[7]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd2, 2'd0};
      vecs[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'd2, 2'd0};
      vecs[9]  = '{4'b0011, 1'b1, 4'b0000, 1'b0, 1'b0, 8'd2, 2'd0};
      vecs[10] = '{4'b0011, 1'b0, 4'b0001, 1'b1, 1'b1, 8'd2, 2'd1};
      vecs[11] = '{4'b1000, 1'b0, 4'b0001, 1'b1, 1'b1, 8'd2, 2'd1};
      vecs[12] = '{4'b1000, 1'b1, 4'b0001, 1'b0, 1'b1, 8'd2, 2'd2};
      vecs[13] = '{4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd3, 2'd0};
      vecs[14] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 1'b1, 8'd3, 2'd1};
      vecs[15] = '{4'b1000, 1'b1, 4'b1000, 1'b0, 1'b1, 8'd3, 2'd2};
      vecs[16] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd4, 2'd0};
      vecs[17] = '{4'b1001, 1'b0, 4'b0001, 1'b1, 1'b1, 8'd4, 2'd1};
      vecs[18] = '{4'b1001, 1'b1, 4'b0001, 1'b0, 1'b1, 8'd4, 2'd2};
      vecs[19] = '{4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd5, 2'd0};
      vecs[20] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 1'b1, 8'd5, 2'd1};
      vecs[21] = '{4'b1001, 1'b1, 4'b1000, 1'b0, 1'b1, 8'd5, 2'd2};
      vecs[22] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd6, 2'd0};

      // ---- reset state ----
      rstNInput  = 1'b0;
      bus.reqIn  = 4'b1111;
      bus.doneIn = 1'b0;
      repeat (3) @(negedge clk);
      check("reset grant", 32'(bus.grantOut), 32'd0);
      check("reset go",    32'(bus.goOut),    32'd0);
      check("reset busy",  32'(bus.busyOut),  32'd0);
      check("reset count", 32'(bus.jobCount), 32'd0);
      check("reset state", 32'(dbg_state),    32'd0);

      // ---- table ----
      do_reset();
      foreach (vecs[i]) begin
         bus.reqIn  = vecs[i].req;
         bus.doneIn = vecs[i].done;
         cycle();
         check($sformatf("vec%0d grant", i), 32'(bus.grantOut), 32'(vecs[i].grant));
         check($sformatf("vec%0d go", i),    32'(bus.goOut),    32'(vecs[i].go));
         check($sformatf("vec%0d busy", i),  32'(bus.busyOut),  32'(vecs[i].busy));
         check($sformatf("vec%0d count", i), 32'(bus.jobCount), 32'(vecs[i].cnt));
         check($sformatf("vec%0d state", i), 32'(dbg_state),    32'(vecs[i].st));
      end

      // ---- all requesters held: strict rotation ----
      do_reset();
      exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      bus.reqIn = 4'b1111;
      for (int j = 0; j < 8; j++) begin
         do_job(g);
         check($sformatf("rotation job%0d", j), 32'(g), 32'(exp_q.pop_front()));
      end
      check("rotation count", 32'(bus.jobCount), 32'd8);

      // ---- owner drops request mid-job ----
      bus.reqIn = 4'b0010;
      wait_busy("drop start", 1'b1);
      check("drop grant", 32'(bus.grantOut), 32'b0010);
      bus.reqIn = 4'b0000;
      for (int j = 0; j < 3; j++) begin
         cycle();
         check($sformatf("drop go hold%0d", j), 32'(bus.goOut), 32'd1);
      end
      do_job(g);
      check("drop count", 32'(bus.jobCount), 32'd9);

      // ---- asynchronous reset mid-job, then synchronized release ----
      bus.reqIn = 4'b0100;
      wait_busy("arst start", 1'b1);
      check("arst go before", 32'(bus.goOut), 32'd1);
      #10;
      rstNInput = 1'b0;
      #1;
      check("arst go",    32'(bus.goOut),    32'd0);
      check("arst grant", 32'(bus.grantOut), 32'd0);
      check("arst busy",  32'(bus.busyOut),  32'd0);
      check("arst count", 32'(bus.jobCount), 32'd0);
      @(negedge clk);
      rstNInput = 1'b1;
      cycle();
      check("sync hold1 busy", 32'(bus.busyOut), 32'd0);
      cycle();
      check("sync hold2 busy", 32'(bus.busyOut), 32'd0);
      cycle();
      check("sync first grant", 32'(bus.grantOut), 32'b0100);
      do_job(g);
      bus.reqIn = 4'b0000;

      // ---- 256 jobs: counter wraps ----
      do_reset();
      bus.reqIn = 4'b0001;
      for (int j = 0; j < 255; j++) do_job(g);
      check("count 255", 32'(bus.jobCount), 32'd255);
      do_job(g);
      check("count wrap", 32'(bus.jobCount), 32'd0);
      bus.reqIn = 4'b0000;

`ifdef JOB_ARBITER_TIMEOUT_EN
      // ---- watchdog with doneIn stuck low ----
      do_reset();
      bus.reqIn = 4'b0011;
      cycle();
      check("wd grant", 32'(bus.grantOut), 32'b0001);
      for (int c = 1; c <= 16; c++) begin
         check($sformatf("wd cycle%0d timeout", c), 32'(bus.timeoutOut), 32'((c == 16) ? 1 : 0));
         if (c < 16) cycle();
      end
      cycle();
      check("wd after timeout", 32'(bus.timeoutOut), 32'd0);
      check("wd after go",      32'(bus.goOut),      32'd0);
      check("wd after state",   32'(dbg_state),      32'd0);
      check("wd after count",   32'(bus.jobCount),   32'd0);
      cycle();
      check("wd next grant", 32'(bus.grantOut), 32'b0010);
      bus.reqIn = 4'b0000;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
